// File: rtl/dma_mem_responder.sv
// Memory-side responder for the DMA nibble interface: descriptor accept, then write sink or read source.
// Optional range checking of descriptors is enabled with `define DMA_MEM_ERR_CHECK_EN.
module dma_mem_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mode,
  input  logic        addr_valid,
  output logic        addr_ready,
  input  logic [31:0] addr,
  input  logic [31:0] len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [3:0]  rd_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned LW = 32;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d, ptr_nx;
  logic [LW-1:0]   remain_q, remain_d;
  logic            addr_ready_d, wr_ready_d, rd_valid_d, busy_d, done_d, err_d;
  logic [3:0]      rd_data_d;
  logic            mem_we;
  logic            range_err;
  logic [3:0]      mem [DEPTH];

`ifdef DMA_MEM_ERR_CHECK_EN
  assign range_err = (addr >= LW'(DEPTH)) ||
                     (({1'b0, addr} + {1'b0, len}) > 33'(DEPTH));
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[LW-1:AW];
  assign range_err      = 1'b0;
`endif

  assign ptr_nx = ptr_q + AW'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    remain_d     = remain_q;
    addr_ready_d = addr_ready;
    wr_ready_d   = wr_ready;
    rd_valid_d   = rd_valid;
    rd_data_d    = rd_data;
    done_d       = 1'b0;
    err_d        = 1'b0;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (addr_valid && addr_ready) begin
          ptr_d    = addr[AW-1:0];
          remain_d = len;
          if (range_err) begin
            err_d = 1'b1;
          end else if (len == '0) begin
            done_d = 1'b1;
          end else if (mode) begin
            state_d      = S_WRITE;
            addr_ready_d = 1'b0;
            wr_ready_d   = 1'b1;
          end else begin
            state_d      = S_READ;
            addr_ready_d = 1'b0;
            rd_valid_d   = 1'b1;
            rd_data_d    = mem[addr[AW-1:0]];
          end
        end
      end
      S_WRITE: begin
        if (wr_valid && wr_ready) begin
          mem_we   = resetn;
          ptr_d    = ptr_nx;
          remain_d = remain_q - LW'(1);
          if (remain_q == LW'(1)) begin
            state_d      = S_IDLE;
            addr_ready_d = 1'b1;
            wr_ready_d   = 1'b0;
            done_d       = 1'b1;
          end
        end
      end
      S_READ: begin
        if (rd_valid && rd_ready) begin
          remain_d = remain_q - LW'(1);
          if (remain_q == LW'(1)) begin
            state_d      = S_IDLE;
            addr_ready_d = 1'b1;
            rd_valid_d   = 1'b0;
            done_d       = 1'b1;
          end else begin
            ptr_d     = ptr_nx;
            rd_data_d = mem[ptr_nx];
          end
        end
      end
      default: begin
        state_d      = S_IDLE;
        addr_ready_d = 1'b1;
        wr_ready_d   = 1'b0;
        rd_valid_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      remain_q   <= '0;
      addr_ready <= 1'b1;
      wr_ready   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      remain_q   <= remain_d;
      addr_ready <= addr_ready_d;
      wr_ready   <= wr_ready_d;
      rd_valid   <= rd_valid_d;
      rd_data    <= rd_data_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  // Storage is deliberately not reset so an aborted transfer keeps its written nibbles
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= wr_data;
  end

endmodule
